io_scan_sched: RTL and testbench
================================

# io_scan_sched

Time-multiplexed pin-identification scheduler for the all-I/O board test. A single shared 8N1 UART serializer walks all `N_PIN` test pins in round-robin order. For each pin it fetches that pin's 4-character label from an external label ROM and transmits the label plus CR LF on that pin only. This replaces one free-running UART transmitter per pin with one engine plus a scheduler. Non-selected pins idle high, so a probe on any pin decodes only its own name.

## Interface
- `N_PIN`, 147: number of scanned pins; `N_PIN >= 2`.
- `CLK_FRE`, 25: clock frequency in MHz.
- `UART_RATE`, 115200: baud rate; `BAUD_DIV = CLK_FRE*1_000_000/UART_RATE`, integer truncation (217 at defaults); `BAUD_DIV >= 2`.
- `GAP_BITS`, 10: idle-high bit times inserted after each pin's frame.
- `AW`, `$clog2(N_PIN)`: label address width (8 at defaults).

- `clk_25M`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  level; scanning runs while high.
- `label_addr`  out  AW  ROM address; always equals `pin_idx`.
- `label_data`  in  32  ROM data, registered, valid 1 cycle after `label_addr`. `[31:24]` is the first character sent.
- `uart_tx`  out  N_PIN  serial outputs; only bit `pin_idx` ever goes low.
- `pin_idx`  out  AW  pin currently or next to be served.
- `busy`  out  1  high in every state except IDLE.
- `scan_done`  out  1  one-cycle pulse when the frame of pin `N_PIN-1` completes.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP, GAP.
- IDLE → FETCH when `en` is sampled high.
- FETCH: 1 cycle; the ROM sees `label_addr = pin_idx`.
- LOAD: 1 cycle; captures `label_data` into a 48-bit shift frame `{label_data, 8'h0D, 8'h0A}` and clears the byte counter.
- START: drive `uart_tx[pin_idx] = 0` for `BAUD_DIV` cycles.
- DATA: drive 8 bits LSB-first, `BAUD_DIV` cycles each.
- STOP: drive 1 for `BAUD_DIV` cycles.
  - If bytes remain in the frame, go to START with the next byte. Bytes are sent in order: label `[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, then `0x0D`, then `0x0A`.
  - After byte 6, go to GAP.
- GAP: line held high for `GAP_BITS*BAUD_DIV` cycles. On exit:
  - `pin_idx` increments, wrapping `N_PIN-1` → 0.
  - `scan_done` pulses on the exit edge from pin `N_PIN-1`'s GAP.
  - Next state is FETCH if `en` is high, otherwise IDLE.
- `en` dropping mid-frame does not truncate; the current pin finishes its frame and GAP, then the block enters IDLE. Rising `en` later resumes at the stored `pin_idx`.
- Label bytes are transmitted verbatim; a space character `0x20` is a valid label byte.
- All `uart_tx` bits other than `pin_idx` are constant 1.
- `uart_tx` is fully registered, so there are no glitches on pin change.
- Counters:
  - Baud counter: `$clog2(BAUD_DIV)` bits, counts 0..`BAUD_DIV-1`.
  - Bit counter: 3 bits.
  - Byte counter: 0..5.
  - Gap counter: sized for `GAP_BITS*BAUD_DIV`.

## Timing
- Reset values:
  - `uart_tx` = all ones; `pin_idx` = 0; `label_addr` = 0.
  - `busy` = 0; `scan_done` = 0; state IDLE.
- `rst` mid-frame: on the next edge all lines return high and scanning restarts at pin 0. No partial character is resumed.
- Let edge k be the edge that samples `en` = 1 in IDLE:
  - `busy` = 1 after edge k.
  - Start bit of byte 1 is low after edge k+2.
- Byte duration is `10*BAUD_DIV` cycles; frame duration is `60*BAUD_DIV` cycles.
- Pin-to-pin period with `en` held: `(60+GAP_BITS)*BAUD_DIV + 2` cycles. This is 15192 at defaults.
- Full scan: `N_PIN` × that period; `scan_done` occurs once per scan.
- Back-to-back bytes within a frame have no extra idle: the stop bit is followed directly by the next start bit.

## Test plan
Directed scenarios use `CLK_FRE=1`, `UART_RATE=250000` (`BAUD_DIV=4`), `N_PIN=4`, `GAP_BITS=2`, with a behavioural ROM holding `"  R2"`, `"  P6"`, `"  R6"`, `"  T1"`.
- Reset, `en`=0 for 100 cycles → `uart_tx` = 4'b1111, `busy` = 0, `pin_idx` = 0, `scan_done` never asserted.
- `en`=1 at edge k → `uart_tx[0]` low from edge k+2 for 4 cycles. A UART monitor on bit 0 decodes `0x20 0x20 0x52 0x32 0x0D 0x0A`. Bits 1–3 remain high throughout.
- `en` held high → pin 1 frame start bit occurs exactly 250 cycles after pin 0's (`62*4+2`). Decoded output on bit 1 is `"  P6\r\n"`, and `scan_done` pulses once, 1 cycle wide, after pin 3's GAP.
- Drop `en` during pin 2 byte 3 → pin 2 still sends all 6 bytes and its GAP, then IDLE with `pin_idx` = 3. Re-raising `en` produces `"  T1\r\n"` on bit 3.
- Assert `rst` for 1 cycle during a DATA low bit on pin 1 → all `uart_tx` high on the next edge; after release with `en`=1, the next start bit appears on bit 0.
- Wrap check: run 2 full scans → order of served pins is 0,1,2,3,0,1,2,3, and exactly 2 `scan_done` pulses occur.

Source files
------------

// File: rtl/io_scan_sched_if.sv
// io_scan_sched_if: enable, label ROM port and per-pin serial lines of the
// pin-identification scan scheduler.
interface io_scan_sched_if #(
    parameter int N_PIN = 147,
    parameter int AW    = $clog2(N_PIN)
);
    logic             en;
    logic [AW-1:0]    label_addr;
    logic [31:0]      label_data;
    logic [N_PIN-1:0] uart_tx;
    logic [AW-1:0]    pin_idx;
    logic             busy;
    logic             scan_done;

    modport master (
        input  en,
        input  label_data,
        output label_addr,
        output uart_tx,
        output pin_idx,
        output busy,
        output scan_done
    );

    modport slave (
        output en,
        output label_data,
        input  label_addr,
        input  uart_tx,
        input  pin_idx,
        input  busy,
        input  scan_done
    );
endinterface

// File: rtl/io_scan_sched.sv
// io_scan_sched: one shared 8N1 serializer that walks every test pin in turn,
// sending that pin's 4-character ROM label plus CR LF on that pin's line only.
// All other lines sit high, so a probe on any pin decodes only its own name.
module io_scan_sched #(
    parameter int N_PIN     = 147,
    parameter int CLK_FRE   = 25,
    parameter int UART_RATE = 115200,
    parameter int GAP_BITS  = 10,
    parameter int AW        = $clog2(N_PIN)
) (
    input  logic            clk_25M,
    input  logic            rst,
    io_scan_sched_if.master bus
);
    localparam int BAUD_DIV = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int GAP_LEN  = GAP_BITS * BAUD_DIV;
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int GW       = $clog2(GAP_LEN + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);
    localparam logic [AW-1:0] PIN_LAST  = AW'(N_PIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t           state, state_n;
    logic [BW-1:0]    baud_cnt, baud_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [2:0]       byte_cnt, byte_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic [47:0]      frame, frame_n;
    logic [AW-1:0]    pin_idx, pin_idx_n;
    logic             done, done_n;
    logic [N_PIN-1:0] tx, tx_n;
    logic [7:0]       cur_byte_n;
    logic             line_n;
    logic             baud_end;

    assign baud_end       = (baud_cnt == BAUD_LAST);
    assign bus.label_addr = pin_idx;
    assign bus.pin_idx    = pin_idx;
    assign bus.busy       = (state != IDLE);
    assign bus.scan_done  = done;
    assign bus.uart_tx    = tx;

    // State register; the serial lines are flops so a pin change cannot glitch.
    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            frame    <= '0;
            pin_idx  <= '0;
            done     <= 1'b0;
            tx       <= '1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            gap_cnt  <= gap_cnt_n;
            frame    <= frame_n;
            pin_idx  <= pin_idx_n;
            done     <= done_n;
            tx       <= tx_n;
        end
    end

    // Next state, counters and the next value of every serial line.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        gap_cnt_n  = gap_cnt;
        frame_n    = frame;
        pin_idx_n  = pin_idx;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                frame_n    = {bus.label_data, 8'h0D, 8'h0A};
                byte_cnt_n = '0;
                bit_cnt_n  = '0;
                baud_cnt_n = '0;
                state_n    = START;
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (byte_cnt == 3'd5) begin
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end else begin
                        byte_cnt_n = byte_cnt + 3'd1;
                        bit_cnt_n  = '0;
                        frame_n    = {frame[39:0], 8'h00};
                        state_n    = START;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    done_n    = (pin_idx == PIN_LAST);
                    pin_idx_n = (pin_idx == PIN_LAST) ? '0 : pin_idx + 1'b1;
                    state_n   = bus.en ? FETCH : IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        cur_byte_n = frame_n[47:40];
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = cur_byte_n[bit_cnt_n];
            default: line_n = 1'b1;
        endcase

        tx_n            = '1;
        tx_n[pin_idx_n] = line_n;
    end
endmodule

// File: tb/tb_io_scan_sched.sv
// tb_io_scan_sched: constant-table checks, directed multi-cycle sequences and
// randomized enable/reset traffic, all compared every cycle against a
// timeline model of the scan schedule.
module tb_io_scan_sched;
    localparam int N_PIN     = 4;
    localparam int CLK_FRE   = 1;
    localparam int UART_RATE = 250000;
    localparam int GAP_BITS  = 2;
    localparam int AW        = 2;
    localparam int BAUD      = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int PERIOD    = (60 + GAP_BITS) * BAUD + 2;

    logic clk_25M = 1'b0;
    logic rst;

    io_scan_sched_if #(.N_PIN(N_PIN), .AW(AW)) bus ();

    io_scan_sched #(
        .N_PIN(N_PIN),
        .CLK_FRE(CLK_FRE),
        .UART_RATE(UART_RATE),
        .GAP_BITS(GAP_BITS),
        .AW(AW)
    ) dut (
        .clk_25M(clk_25M),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_25M = ~clk_25M;

    // Registered label ROM: data follows the address by one clock.
    logic [31:0] rom [N_PIN];
    always @(posedge clk_25M) bus.label_data <= rom[bus.label_addr];

    typedef struct {
        logic       rst;
        logic       en;
        int         cycles;
        logic [3:0] tx;
        logic       busy;
        logic [1:0] pin;
        logic       done;
    } vec_t;

    typedef struct {
        logic [AW-1:0] pin;
        logic [7:0]    data;
        int            start;
    } rx_t;

    vec_t vecs [20];
    rx_t  rx_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_wide = 0;
    bit prev_done = 1'b0;

    bit m_active = 1'b0;
    int m_t      = 0;
    int m_pin    = 0;
    bit m_done   = 1'b0;

    bit         rx_busy  [N_PIN];
    int         rx_cnt   [N_PIN];
    logic [7:0] rx_sh    [N_PIN];
    int         rx_start [N_PIN];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte b (0..5) of the frame sent for pin p: four label bytes, CR, LF.
    function automatic logic [7:0] frame_byte(input int p, input int b);
        case (b)
            0:       return rom[p][31:24];
            1:       return rom[p][23:16];
            2:       return rom[p][15:8];
            3:       return rom[p][7:0];
            4:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Line level at offset t of a pin's slot: 2 setup cycles, 6 ten-bit
    // characters, then the idle gap.
    function automatic logic exp_line(input int p, input int t);
        int u;
        int s;
        logic [7:0] ch;
        if (t < 2 || t >= 2 + 60 * BAUD) return 1'b1;
        u  = t - 2;
        s  = (u % (10 * BAUD)) / BAUD;
        ch = frame_byte(p, u / (10 * BAUD));
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return ch[s - 1];
    endfunction

    function automatic logic [63:0] model_outputs();
        logic [N_PIN-1:0] tx;
        tx = '1;
        if (m_active) tx[m_pin] = exp_line(m_pin, m_t);
        return 64'({tx, m_active, AW'(m_pin), AW'(m_pin), m_done});
    endfunction

    // Advance the slot timeline by one clock using the inputs seen at the edge.
    task automatic model_step();
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_pin    = 0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (bus.en) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (m_t == PERIOD - 1) begin
            m_done   = (m_pin == N_PIN - 1);
            m_pin    = (m_pin + 1) % N_PIN;
            m_active = bus.en;
            m_t      = 0;
        end else begin
            m_t++;
            m_done = 1'b0;
        end
    endtask

    // Software 8N1 receivers, one per pin, sampling mid-bit.
    task automatic rx_step(input logic rst_seen);
        int idx;
        for (int p = 0; p < N_PIN; p++) begin
            if (rst_seen) begin
                rx_busy[p] = 1'b0;
            end else if (!rx_busy[p]) begin
                if (bus.uart_tx[p] === 1'b0) begin
                    rx_busy[p]  = 1'b1;
                    rx_cnt[p]   = 0;
                    rx_start[p] = cyc;
                end
            end else begin
                rx_cnt[p]++;
                if (rx_cnt[p] >= BAUD + BAUD / 2 && (rx_cnt[p] - BAUD / 2) % BAUD == 0) begin
                    idx = (rx_cnt[p] - BAUD / 2) / BAUD - 1;
                    if (idx < 8) begin
                        rx_sh[p][idx[2:0]] = bus.uart_tx[p];
                    end else begin
                        rx_busy[p] = 1'b0;
                        if (bus.uart_tx[p] === 1'b1) rx_q.push_back('{AW'(p), rx_sh[p], rx_start[p]});
                    end
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        logic rst_seen;
        @(posedge clk_25M);
        rst_seen = rst;
        model_step();
        @(negedge clk_25M);
        cyc++;
        checkOutput("model", 64'({bus.uart_tx, bus.busy, bus.pin_idx, bus.label_addr, bus.scan_done}),
                    model_outputs());
        rx_step(rst_seen);
        if (bus.scan_done === 1'b1) begin
            done_cnt++;
            if (prev_done) done_wide++;
        end
        prev_done = (bus.scan_done === 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_dut();
        bus.en = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        done_cnt  = 0;
        done_wide = 0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        rst    = v.rst;
        bus.en = v.en;
        run(v.cycles);
        checkOutput($sformatf("vec%0d", idx),
                    64'({bus.uart_tx, bus.busy, bus.pin_idx, bus.scan_done}),
                    64'({v.tx, v.busy, v.pin, v.done}));
    endtask

    initial begin
        int n;
        int k_cyc;
        int p_exp;

        rst    = 1'b1;
        bus.en = 1'b0;
        rom[0] = 32'h2020_5232;
        rom[1] = 32'h2020_5036;
        rom[2] = 32'h2020_5236;
        rom[3] = 32'h2020_5431;

        vecs[0]  = '{1'b1, 1'b0,   2, 4'hF, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 100, 4'hF, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1,   1, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1,   1, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1,   1, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1,   3, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1,   1, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1,  20, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1,   4, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1,  56, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 163, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1,   1, 4'hF, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b1,   2, 4'hD, 1'b1, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 747, 4'hF, 1'b1, 2'd3, 1'b0};
        vecs[14] = '{1'b0, 1'b1,   1, 4'hF, 1'b1, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 1'b1,   1, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[16] = '{1'b0, 1'b0,   1, 4'hE, 1'b1, 2'd0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 247, 4'hF, 1'b1, 2'd0, 1'b0};
        vecs[18] = '{1'b0, 1'b0,   1, 4'hF, 1'b0, 2'd1, 1'b0};
        vecs[19] = '{1'b0, 1'b0,  50, 4'hF, 1'b0, 2'd1, 1'b0};

        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

        // Two full scans with en held: byte content, pin order, period, scan_done.
        reset_dut();
        bus.en = 1'b1;
        k_cyc  = cyc + 1;
        run(2005);
        bus.en = 1'b0;
        checkOutput("scan_byte_count", 64'(rx_q.size()), 64'd48);
        for (int i = 0; i < rx_q.size() && i < 48; i++) begin
            p_exp = (i / 6) % N_PIN;
            checkOutput($sformatf("scan_rx%0d", i), 64'({rx_q[i].pin, rx_q[i].data}),
                        64'({AW'(p_exp), frame_byte(p_exp, i % 6)}));
        end
        if (rx_q.size() >= 7) begin
            checkOutput("first_start", 64'(rx_q[0].start - k_cyc), 64'd2);
            checkOutput("pin_period", 64'(rx_q[6].start - rx_q[0].start), 64'(PERIOD));
        end
        checkOutput("done_count", 64'(done_cnt), 64'd2);
        checkOutput("done_width", 64'(done_wide), 64'd0);

        // Drop en during pin 2's third character: frame and gap complete, then idle.
        reset_dut();
        bus.en = 1'b1;
        run(591);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 600) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", 64'(bus.busy), 64'd0);
        checkOutput("idle_pin", 64'(bus.pin_idx), 64'd3);
        checkOutput("drop_byte_count", 64'(rx_q.size()), 64'd18);
        for (int i = 12; i < 18 && i < rx_q.size(); i++) begin
            checkOutput($sformatf("drop_rx%0d", i), 64'({rx_q[i].pin, rx_q[i].data}),
                        64'({2'd2, frame_byte(2, i - 12)}));
        end
        run(20);
        checkOutput("idle_hold", 64'({bus.uart_tx, bus.busy}), 64'({4'hF, 1'b0}));
        rx_q.delete();
        bus.en = 1'b1;
        run(260);
        checkOutput("resume_byte_count", 64'(rx_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checkOutput($sformatf("resume_rx%0d", i), 64'({rx_q[i].pin, rx_q[i].data}),
                        64'({2'd3, frame_byte(3, i)}));
        end

        // Reset during a low data bit on pin 1, then restart from pin 0.
        reset_dut();
        bus.en = 1'b1;
        run(258);
        checkOutput("pre_rst_low", 64'(bus.uart_tx), 64'(4'hD));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_lines", 64'({bus.uart_tx, bus.busy, bus.pin_idx}), 64'({4'hF, 1'b0, 2'd0}));
        n = 0;
        while (bus.uart_tx === 4'hF && n < 10) begin
            tick();
            n++;
        end
        checkOutput("restart_pin0", 64'(bus.uart_tx), 64'(4'hE));
        checkOutput("restart_latency", 64'(n), 64'd3);

        // Random labels and random en/rst traffic against the timeline model.
        bus.en = 1'b0;
        rst    = 1'b1;
        for (int p = 0; p < N_PIN; p++) rom[p] = $urandom();
        rom[0][15:8] = 8'h20;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 149) == 0) bus.en = ~bus.en;
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
